// File: rtl/sw_buf_ctrl.sv
// sw_buf_ctrl: search-window buffer controller.
// Fills a circular pixel buffer on command, keeps it as a sliding window in RUN,
// and streams it to the PE array with strobes aligned to the pixel read-out.
module sw_buf_ctrl #(
    parameter int unsigned WORD_WIDETH = 8,
    parameter int unsigned DEPTH       = 24,
    parameter int unsigned AW          = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             ctr_word,
    input  logic                   mem_en_input,
    input  logic                   mem_init_mode,
    input  logic [WORD_WIDETH-1:0] pix_in,
    input  logic                   pix_in_valid,
    output logic [WORD_WIDETH-1:0] pix_out,
    output logic                   pix_out_valid,
    output logic                   pe_shift,
    output logic                   acc_clr,
    output logic                   init_done,
    output logic                   err_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_e                 state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [WORD_WIDETH-1:0] pix_out_q, pix_out_d;
    logic                   pix_out_valid_q, pix_out_valid_d;
    logic                   pe_shift_q, pe_shift_d;
    logic                   acc_clr_q, acc_clr_d;
    logic                   init_done_q, init_done_d;
    logic                   err_ovf_q, err_ovf_d;

    logic                   wr_en_c;
    logic                   rd_en_c;
    logic [AW-1:0]          rd_addr_c;
    logic                   init_cmd_c;

    logic [WORD_WIDETH-1:0] mem_q [DEPTH];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    assign init_cmd_c = mem_en_input & mem_init_mode;

    // Next-state, pointer and output-register computation.
    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        wr_en_c         = 1'b0;
        rd_en_c         = 1'b0;
        rd_addr_c       = rd_ptr_q;
        pix_out_valid_d = 1'b0;
        pe_shift_d      = 1'b0;
        acc_clr_d       = 1'b0;
        init_done_d     = 1'b0;
        // A pixel offered without a write enable is dropped and flagged.
        err_ovf_d       = err_ovf_q | (pix_in_valid & ~mem_en_input);

        case (state_q)
            IDLE: begin
                if (init_cmd_c) begin
                    state_d   = INIT;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    err_ovf_d = 1'b0;
                end
            end
            INIT: begin
                if (pix_in_valid && mem_en_input) begin
                    wr_en_c = 1'b1;
                    if (wr_ptr_q == LAST_PTR) begin
                        wr_ptr_d    = '0;
                        init_done_d = 1'b1;
                        state_d     = RUN;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end
            end
            RUN: begin
                if (init_cmd_c) begin
                    // Restart: no write, no read this cycle.
                    state_d   = INIT;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    err_ovf_d = 1'b0;
                end else begin
                    if (pix_in_valid && mem_en_input) begin
                        wr_en_c  = 1'b1;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                    end
                    // Rewind points the read at the oldest entry (current write slot).
                    if (ctr_word[3]) begin
                        rd_addr_c = wr_ptr_q;
                        rd_ptr_d  = wr_ptr_q;
                    end
                    if (ctr_word[0]) begin
                        rd_en_c         = 1'b1;
                        rd_ptr_d        = ptr_inc(rd_addr_c);
                        pix_out_valid_d = 1'b1;
                    end
                    pe_shift_d = ctr_word[1];
                    acc_clr_d  = ctr_word[2];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read-before-write: the read port sees the array before this cycle's write.
    always_comb begin
        pix_out_d = pix_out_q;
        if (rd_en_c) begin
            pix_out_d = mem_q[rd_addr_c];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            pix_out_q       <= '0;
            pix_out_valid_q <= 1'b0;
            pe_shift_q      <= 1'b0;
            acc_clr_q       <= 1'b0;
            init_done_q     <= 1'b0;
            err_ovf_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            pix_out_q       <= pix_out_d;
            pix_out_valid_q <= pix_out_valid_d;
            pe_shift_q      <= pe_shift_d;
            acc_clr_q       <= acc_clr_d;
            init_done_q     <= init_done_d;
            err_ovf_q       <= err_ovf_d;
        end
    end

    // Pixel storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= pix_in;
        end
    end

    assign pix_out       = pix_out_q;
    assign pix_out_valid = pix_out_valid_q;
    assign pe_shift      = pe_shift_q;
    assign acc_clr       = acc_clr_q;
    assign init_done     = init_done_q;
    assign err_ovf       = err_ovf_q;

endmodule

// File: tb/tb_sw_buf_ctrl.sv
// tb_sw_buf_ctrl: directed self-checking bench for sw_buf_ctrl.
module tb_sw_buf_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic [3:0]   ctr_word;
    logic         mem_en_input;
    logic         mem_init_mode;
    logic [W-1:0] pix_in;
    logic         pix_in_valid;
    logic [W-1:0] pix_out;
    logic         pix_out_valid;
    logic         pe_shift;
    logic         acc_clr;
    logic         init_done;
    logic         err_ovf;

    int n_cmp;
    int n_bad;

    sw_buf_ctrl #(
        .WORD_WIDETH (W),
        .DEPTH       (24),
        .AW          (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ctr_word      (ctr_word),
        .mem_en_input  (mem_en_input),
        .mem_init_mode (mem_init_mode),
        .pix_in        (pix_in),
        .pix_in_valid  (pix_in_valid),
        .pix_out       (pix_out),
        .pix_out_valid (pix_out_valid),
        .pe_shift      (pe_shift),
        .acc_clr       (acc_clr),
        .init_done     (init_done),
        .err_ovf       (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic mode, input logic vld,
                         input logic [W-1:0] px, input logic [3:0] cw);
        mem_en_input  = en;
        mem_init_mode = mode;
        pix_in_valid  = vld;
        pix_in        = px;
        ctr_word      = cw;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".pix_out"}, 32'(pix_out), 32'h0);
        check_val({tag, ".valid"},   32'(pix_out_valid), 32'h0);
        check_val({tag, ".pe"},      32'(pe_shift), 32'h0);
        check_val({tag, ".acc"},     32'(acc_clr), 32'h0);
        check_val({tag, ".done"},    32'(init_done), 32'h0);
        check_val({tag, ".err"},     32'(err_ovf), 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        step();
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Read command in IDLE produces nothing.
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'b0001);
        step();
        check_val("idle_read.valid", 32'(pix_out_valid), 32'h0);

        // Init command (no write on the command cycle).
        drive(1'b1, 1'b1, 1'b0, 8'h00, 4'b0000);
        step();
        check_val("init_cmd.done", 32'(init_done), 32'h0);

        // Fill 0..23; mode held high (ignored in INIT) except on the last write;
        // ctr_word=0111 must not produce strobes in INIT.
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, (i == 23) ? 1'b0 : 1'b1, 1'b1, W'(i), 4'b0111);
            step();
            check_val($sformatf("fill%0d.done", i), 32'(init_done), (i == 23) ? 32'h1 : 32'h0);
            check_val($sformatf("fill%0d.strobes", i),
                      32'({pix_out_valid, pe_shift, acc_clr}), 32'h0);
        end

        // 25 reads: 0..23 then wrap to 0.
        for (int i = 0; i < 25; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 4'b0001);
            step();
            if (i == 0) check_val("read0.done_clear", 32'(init_done), 32'h0);
            check_val($sformatf("read%0d.valid", i), 32'(pix_out_valid), 32'h1);
            check_val($sformatf("read%0d.pix", i), 32'(pix_out), 32'(i % 24));
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        check_val("idle_cyc.valid", 32'(pix_out_valid), 32'h0);
        check_val("idle_cyc.hold", 32'(pix_out), 32'h0);

        // Strobe alignment: rd_ptr is at entry 1.
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'b0111);
        step();
        check_val("strobe.all", 32'({pix_out_valid, pe_shift, acc_clr}), 32'h7);
        check_val("strobe.pix", 32'(pix_out), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        check_val("strobe.after", 32'({pix_out_valid, pe_shift, acc_clr}), 32'h0);

        // Sliding window: overwrite entries 0..3 with 100..103.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, W'(100 + i), 4'b0000);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'b1001);
        step();
        check_val("slide0.pix", 32'(pix_out), 32'd4);
        for (int j = 1; j < 24; j++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 4'b0001);
            step();
            check_val($sformatf("slide%0d.pix", j), 32'(pix_out),
                      (j < 20) ? 32'(4 + j) : 32'(100 + j - 20));
        end

        // Collision: fill window with 0xAA (wr/rd both end at 4), then read+write at 4.
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'hAA, 4'b0000);
            step();
        end
        drive(1'b1, 1'b0, 1'b1, 8'h55, 4'b0001);
        step();
        check_val("collide.pix", 32'(pix_out), 32'hAA);
        for (int i = 0; i < 24; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 4'b0001);
            step();
            if (i == 22) check_val("collide.old_neighbor", 32'(pix_out), 32'hAA);
            if (i == 23) check_val("collide.new_data", 32'(pix_out), 32'h55);
        end

        // Protocol error: pixel without enable is dropped and the flag sticks.
        drive(1'b0, 1'b0, 1'b1, 8'hEE, 4'b0000);
        step();
        check_val("err.set", 32'(err_ovf), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        check_val("err.sticky", 32'(err_ovf), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'b1001);
        step();
        check_val("err.buf_unchanged", 32'(pix_out), 32'hAA);

        // Re-init mid-RUN with a pixel and read on the command cycle: neither happens.
        drive(1'b1, 1'b1, 1'b1, 8'h77, 4'b0001);
        step();
        check_val("reinit.err_clr", 32'(err_ovf), 32'h0);
        check_val("reinit.valid", 32'(pix_out_valid), 32'h0);
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 1'b0, 1'b1, W'(200 + i), 4'b0001);
            step();
            check_val($sformatf("refill%0d.valid", i), 32'(pix_out_valid), 32'h0);
            check_val($sformatf("refill%0d.done", i), 32'(init_done), (i == 23) ? 32'h1 : 32'h0);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'b0111);
        step();
        check_val("refill_read.strobes", 32'({pix_out_valid, pe_shift, acc_clr}), 32'h7);
        check_val("refill_read.pix", 32'(pix_out), 32'd200);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'b0111);
        step();
        check_val("pre_rst.pix", 32'(pix_out), 32'd201);

        // Asynchronous reset mid-cycle clears outputs at once.
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'b0001);
        step();
        check_val("post_rst.valid", 32'(pix_out_valid), 32'h0);
        step();
        check_val("post_rst.valid2", 32'(pix_out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sw_buf_ctrl.md
Name: sw_buf_ctrl

Overview:
- Receiving end of the block-matching controller's command interface.
- Consumes the 4-bit control word and the memory enable/init strobes, and owns a circular search-window pixel buffer.
- The buffer is filled from the pixel input stream and read out to the PE array on command.
- Registered PE-side strobes are kept cycle-aligned with the pixel read-out.

Parameters:
- WORD_WIDETH, 8, pixel width in bits.
- DEPTH, 24, buffer entries; matches the 24-cycle controller period; must be ≥2.
- AW, 5, pointer width; must satisfy 2^AW ≥ DEPTH.

Ports:
- clk  input  1  sole clock; all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- ctr_word  input  4  command from controller:
  - bit0 read
  - bit1 PE shift
  - bit2 accumulator clear
  - bit3 read-pointer rewind
- mem_en_input  input  1  write enable for the buffer.
- mem_init_mode  input  1  with mem_en_input: (re)start an initial fill.
- pix_in  input  WORD_WIDETH  incoming search-window pixel.
- pix_in_valid  input  1  pix_in qualifier.
- pix_out  output  WORD_WIDETH  pixel to PE array.
- pix_out_valid  output  1  pix_out qualifier.
- pe_shift  output  1  PE array shift strobe.
- acc_clr  output  1  SAD accumulator clear strobe.
- init_done  output  1  one-cycle pulse when the initial fill completes.
- err_ovf  output  1  sticky protocol error.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; wr_ptr=rd_ptr=0.
  - All outputs 0, including pix_out and err_ovf.
  - Buffer contents are not reset.
- Reset mid-operation: rst dominates immediately; any fill in progress is abandoned; a new fill requires a new init command.
- States:
  - IDLE → INIT on mem_en_input=1 & mem_init_mode=1.
  - INIT → RUN on the write that completes the fill.
  - RUN → INIT on mem_en_input=1 & mem_init_mode=1.
- Entering INIT: wr_ptr=0, rd_ptr=0, err_ovf cleared.
- INIT:
  - Each cycle with pix_in_valid=1 & mem_en_input=1 writes buf[wr_ptr]; wr_ptr increments.
  - The write at wr_ptr=DEPTH-1 wraps wr_ptr to 0, pulses init_done=1 the next cycle (exactly one cycle) and moves to RUN.
  - The mem_init_mode level is ignored once in INIT.
  - ctr_word is ignored; pix_out_valid, pe_shift and acc_clr stay 0.
- RUN writes (sliding window):
  - pix_in_valid=1 & mem_en_input=1 & mem_init_mode=0 overwrites buf[wr_ptr], the oldest entry.
  - wr_ptr increments mod DEPTH.
- RUN reads:
  - ctr_word[0]=1 reads buf[rd_ptr]; rd_ptr increments mod DEPTH (DEPTH-1 → 0).
  - pix_out and pix_out_valid are registered; latency is 1 cycle from ctr_word sampling.
  - pix_out holds its last value when not reading; pix_out_valid=0 on non-read cycles.
- Rewind: ctr_word[3]=1 loads rd_ptr from wr_ptr (the oldest entry). With bit0 also set, rewind wins: that entry is read and rd_ptr becomes wr_ptr+1 mod DEPTH.
- Same-address read and write in one cycle: read-before-write; pix_out returns the old data.
- pe_shift and acc_clr: registered copies of ctr_word[1] and ctr_word[2], in RUN only; 1-cycle latency, aligned with pix_out_valid.
- err_ovf:
  - Set when pix_in_valid=1 & mem_en_input=0, in any state.
  - Sticky; cleared only by rst or by entry to INIT.
  - The offending pixel is dropped.
- Simultaneous init command and pixel write in RUN: no write occurs that cycle; the first INIT write happens on the next valid cycle.
- Pointers never exceed DEPTH-1. There is no full/empty notion: the buffer is a fixed window, and overwriting in RUN is intended.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately; state IDLE; ctr_word=4'b0001 then produces no pix_out_valid.
- Init fill: init command, then pixels 0..23 with valid every cycle → init_done high exactly 1 cycle after pixel 23 is written; 24 reads (ctr_word=4'b0001) return 0..23 each 1 cycle later; rd_ptr wraps, so read 25 returns 0.
- Sliding window: after the fill, write pixels 100..103 in RUN, then rewind + read 24 → pix_out sequence 4..23,100,101,102,103.
- Strobe alignment: ctr_word=4'b0111 for one cycle → pix_out_valid, pe_shift and acc_clr all high together on the following cycle only; in INIT the same word → all 0.
- Protocol error: pix_in_valid=1 with mem_en_input=0 → err_ovf=1 and held, buffer unchanged; a new init command → err_ovf cleared the next cycle.
- Collision and re-init: read and write the same address with data 0x55 over old 0xAA → pix_out=0xAA; init command mid-RUN → pointers 0, pix_out_valid 0 until the next fill completes.
